sm4_block_packer: RTL

- Upstream feeder for the SM4 encryptor.
- Accepts a 32-bit word stream and assembles four words into one 128-bit content group.
- Captures the key and the encode/decode flag with each group, then issues the group over a valid/ready handshake to the encryptor's v_i/ready_o.
- Double-buffered: the next group assembles while the current group waits for the encryptor.

---
 rtl/sm4_block_packer_if.sv | 31 +++
 rtl/sm4_block_packer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sm4_block_packer_if.sv
// Word-stream / SM4-group bus between the block packer (slave) and its environment (master).
interface sm4_block_packer_if #(
  parameter int word_width_p = 32,
  parameter int group_size_p = 128
);
  logic [word_width_p-1:0] word_i;
  logic                    word_v_i;
  logic                    word_ready_o;
  logic [group_size_p-1:0] key_i;
  logic                    decode_i;
  logic [group_size_p-1:0] content_o;
  logic [group_size_p-1:0] key_o;
  logic                    decode_o;
  logic                    v_o;
  logic                    ready_i;
  logic [group_size_p-1:0] crypt_i;
  logic                    crypt_ack_i;
  logic [group_size_p-1:0] iv_i;
  logic                    iv_load_i;
  logic                    busy_o;

  modport slave (
    input  word_i, word_v_i, key_i, decode_i, ready_i, crypt_i, crypt_ack_i, iv_i, iv_load_i,
    output word_ready_o, content_o, key_o, decode_o, v_o, busy_o
  );

  modport master (
    output word_i, word_v_i, key_i, decode_i, ready_i, crypt_i, crypt_ack_i, iv_i, iv_load_i,
    input  word_ready_o, content_o, key_o, decode_o, v_o, busy_o
  );
endinterface

// File: rtl/sm4_block_packer.sv
// Packs four words into one SM4 group (word 0 at [31:0]), double-buffered; v_o one edge after word 3, word_ready_o low while asm is full.
// Optional CBC chaining of encrypt groups under `SM4_PACKER_CBC_EN; default build is ECB only.
module sm4_block_packer #(
  parameter int word_width_p = 32,
  parameter int group_size_p = 128
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  sm4_block_packer_if.slave io
);

  logic                    alive_q;
  logic [1:0]              cnt_q, cnt_d;
  logic [group_size_p-1:0] asm_q, asm_d;
  logic [group_size_p-1:0] asm_key_q, asm_key_d;
  logic                    asm_dec_q, asm_dec_d;
  logic                    asm_full_q, asm_full_d;
  logic [group_size_p-1:0] out_q, out_d;
  logic [group_size_p-1:0] out_key_q, out_key_d;
  logic                    out_dec_q, out_dec_d;
  logic                    out_full_q, out_full_d;
  logic                    in_flight_q, in_flight_d;

  logic word_ready;
  logic word_acc;
  logic out_vld;
  logic out_fire;
  logic xfer;
  logic cbc_gate;

  // alive_q keeps word_ready_o low until the first edge after reset release
  assign word_ready = alive_q & ~asm_full_q;
  assign word_acc   = io.word_v_i & word_ready;
  assign out_vld    = out_full_q & ~cbc_gate;
  assign out_fire   = out_vld & io.ready_i;
  assign xfer       = asm_full_q & (~out_full_q | out_fire);

  always_comb begin
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    asm_key_d   = asm_key_q;
    asm_dec_d   = asm_dec_q;
    asm_full_d  = asm_full_q;
    out_d       = out_q;
    out_key_d   = out_key_q;
    out_dec_d   = out_dec_q;
    out_full_d  = out_full_q;
    in_flight_d = in_flight_q;

    if (word_acc) begin
      asm_d[int'(cnt_q) * word_width_p +: word_width_p] = io.word_i;
      if (cnt_q == 2'd0) begin
        asm_key_d = io.key_i;
        asm_dec_d = io.decode_i;
      end
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        asm_full_d = 1'b1;
      end
    end

    if (xfer) begin
      asm_full_d = 1'b0;
      out_d      = asm_q;
      out_key_d  = asm_key_q;
      out_dec_d  = asm_dec_q;
      out_full_d = 1'b1;
    end else if (out_fire) begin
      out_full_d = 1'b0;
    end

    // a new issue on the same edge as an ack leaves a group in flight
    if (out_fire) begin
      in_flight_d = 1'b1;
    end else if (io.crypt_ack_i) begin
      in_flight_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      alive_q     <= 1'b0;
      cnt_q       <= 2'd0;
      asm_q       <= '0;
      asm_key_q   <= '0;
      asm_dec_q   <= 1'b0;
      asm_full_q  <= 1'b0;
      out_q       <= '0;
      out_key_q   <= '0;
      out_dec_q   <= 1'b0;
      out_full_q  <= 1'b0;
      in_flight_q <= 1'b0;
    end else begin
      alive_q     <= 1'b1;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      asm_key_q   <= asm_key_d;
      asm_dec_q   <= asm_dec_d;
      asm_full_q  <= asm_full_d;
      out_q       <= out_d;
      out_key_q   <= out_key_d;
      out_dec_q   <= out_dec_d;
      out_full_q  <= out_full_d;
      in_flight_q <= in_flight_d;
    end
  end

`ifdef SM4_PACKER_CBC_EN
  logic [group_size_p-1:0] chain_q, chain_d;
  logic                    flight_dec_q, flight_dec_d;

  // chain source: returned ciphertext (encrypt) or issued ciphertext (decrypt); an IV load overrides both
  always_comb begin
    chain_d      = chain_q;
    flight_dec_d = flight_dec_q;
    if (out_fire) begin
      flight_dec_d = out_dec_q;
    end
    if (io.crypt_ack_i && in_flight_q && !flight_dec_q) begin
      chain_d = io.crypt_i;
    end
    if (out_fire && out_dec_q) begin
      chain_d = out_q;
    end
    if (io.iv_load_i) begin
      chain_d = io.iv_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      chain_q      <= '0;
      flight_dec_q <= 1'b0;
    end else begin
      chain_q      <= chain_d;
      flight_dec_q <= flight_dec_d;
    end
  end

  assign cbc_gate     = in_flight_q;
  assign io.content_o = out_dec_q ? out_q : (out_q ^ chain_q);
`else
  logic unused_ecb;
  assign unused_ecb   = ^{io.iv_i, io.iv_load_i, io.crypt_i};
  assign cbc_gate     = 1'b0;
  assign io.content_o = out_q;
`endif

  assign io.word_ready_o = word_ready;
  assign io.key_o        = out_key_q;
  assign io.decode_o     = out_dec_q;
  assign io.v_o          = out_vld;
  assign io.busy_o       = (cnt_q != 2'd0) | asm_full_q | out_full_q | in_flight_q;

endmodule
